// File: rtl/blinkt_frame_sequencer.sv
// Wishbone-controlled frame sequencer for the APA102 LED bar: shadow pixels, snapshot on commit, streamed frame.
// Optional auto-refresh timer enabled by defining BLINKT_AUTO_REFRESH_EN.
module blinkt_frame_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SELECT_WIDTH   = DATA_WIDTH/8,
  parameter int NUM_LEDS       = 8,
  parameter int REFRESH_CYCLES = 24000000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic                    wb_we_i,
  input  logic [SELECT_WIDTH-1:0] wb_sel_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_cyc_i,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    wb_rty_o,
  output logic [31:0]             m_axis_data,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    o_busy,
  output logic                    o_frame_done
);

  localparam logic [4:0] NLED = 5'(NUM_LEDS);
  localparam logic [3:0] LAST = 4'(NUM_LEDS-1);

  typedef enum logic [1:0] {IDLE, START, LED, END} state_t;
  state_t state, state_nxt;

  logic [15:0][31:0] shadow, snap;
  logic [3:0]        idx;
  logic              pending;
  logic [7:0]        frame_count;
  logic [4:0]        word;
  logic              accept, wr, ctrl_wr, commit, auto_commit, xfer, end_xfer, start_frame;
  logic              auto_bit;
  logic [31:0]       rdata, ctrl_rdata;

  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;

  assign word    = wb_adr_i[6:2];
  assign accept  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr      = accept & wb_we_i;
  assign ctrl_wr = wr && (word == 5'd16);
  assign commit  = (ctrl_wr & wb_dat_i[0]) | auto_commit;

  assign xfer        = m_axis_tvalid & m_axis_tready;
  assign end_xfer    = (state == END) & xfer;
  // A commit landing on the end-word transfer chains straight into the next frame.
  assign start_frame = ((state == IDLE) & commit) | (end_xfer & (pending | commit));

`ifdef BLINKT_AUTO_REFRESH_EN
  localparam logic [31:0] RELOAD = 32'(REFRESH_CYCLES-1);
  logic        auto_en;
  logic [31:0] refresh_cnt;

  assign auto_commit = auto_en && (refresh_cnt == 32'd0) && (state == IDLE);
  assign auto_bit    = 1'b1;
  assign ctrl_rdata  = {30'b0, auto_en, 1'b0};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      auto_en     <= 1'b1;
      refresh_cnt <= RELOAD;
    end else begin
      if (ctrl_wr) auto_en <= wb_dat_i[1];
      if (start_frame)                          refresh_cnt <= RELOAD;
      else if (auto_en && refresh_cnt != 32'd0) refresh_cnt <= refresh_cnt - 32'd1;
    end
  end
`else
  assign auto_commit = 1'b0;
  assign auto_bit    = 1'b0;
  assign ctrl_rdata  = 32'd0;
`endif

  logic unused_bits;
  assign unused_bits = ^{wb_adr_i[ADDR_WIDTH-1:7], wb_adr_i[1:0], 32'(REFRESH_CYCLES)};

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (commit) state_nxt = START;
      START: if (xfer) state_nxt = LED;
      LED:   if (xfer && idx == LAST) state_nxt = END;
      END:   if (xfer) state_nxt = (pending | commit) ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_axis_data = 32'h0000_0000;
    case (state)
      LED:     m_axis_data = {3'b111, snap[idx][28:0]};
      END:     m_axis_data = 32'hFFFF_FFFF;
      default: m_axis_data = 32'h0000_0000;
    endcase
  end

  assign m_axis_tvalid = (state != IDLE);
  assign o_busy        = (state != IDLE);
  assign o_frame_done  = end_xfer;

  always_comb begin
    rdata = 32'd0;
    if (word < NLED)        rdata = shadow[word[3:0]];
    else if (word == 5'd16) rdata = ctrl_rdata;
    else if (word == 5'd17) rdata = {16'b0, frame_count, 5'b0, auto_bit, pending, o_busy};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= '0;
      shadow      <= '0;
      snap        <= '0;
      idx         <= '0;
      pending     <= 1'b0;
      frame_count <= '0;
    end else begin
      wb_ack_o <= accept;
      if (accept) wb_dat_o <= wb_we_i ? 32'd0 : rdata;
      if (wr && word < NLED)
        for (int b = 0; b < SELECT_WIDTH; b++)
          if (wb_sel_i[b]) shadow[word[3:0]][8*b +: 8] <= wb_dat_i[8*b +: 8];
      if (start_frame) begin
        snap <= shadow;
        idx  <= '0;
      end else if (state == LED && xfer) begin
        idx <= idx + 4'd1;
      end
      if (end_xfer)             pending <= 1'b0;
      else if (commit && o_busy) pending <= 1'b1;
      if (end_xfer) frame_count <= frame_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_blinkt_frame_sequencer.sv
// Directed bench for blinkt_frame_sequencer: a reference pixel model feeds an expected-word queue checked at each stream transfer.
module tb_blinkt_frame_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
  logic        wb_we_i = 1'b0, wb_stb_i = 1'b0, wb_cyc_i = 1'b0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_ack_o, wb_err_o, wb_rty_o;
  logic [31:0] m_axis_data;
  logic        m_axis_tvalid, o_busy, o_frame_done;
  logic        m_axis_tready = 1'b1;

  blinkt_frame_sequencer dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
    .m_axis_data(m_axis_data), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  logic [31:0] expq[$];
  logic [31:0] model[8];
  logic        stalled = 1'b0;
  logic [31:0] held = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Stream monitor: every transfer pops one expected word; stalled words must hold.
  always @(negedge i_clk) begin
    if (i_rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", {31'b0, m_axis_tvalid}, 32'd1);
        check("hold_data", m_axis_data, held);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (expq.size() == 0) check("unexpected_xfer", {31'b0, m_axis_tvalid}, 32'd0);
        else check("axis_word", m_axis_data, expq.pop_front());
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      held    = m_axis_data;
      if (o_frame_done) done_cnt++;
    end
  end

  task automatic wb(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic we, output logic [31:0] r);
    int k = 0;
    @(posedge i_clk) #1;
    wb_adr_i = a; wb_dat_i = d; wb_sel_i = s; wb_we_i = we; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge i_clk) #1;
    while (!wb_ack_o && k < 10) begin @(posedge i_clk) #1; k++; end
    check("wb_ack", {31'b0, wb_ack_o}, 32'd1);
    r = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    if (we && a[6:2] < 5'd8)
      for (int b = 0; b < 4; b++)
        if (s[b]) model[a[4:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    wb(a, d, s, 1'b1, r);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    wb(a, 32'd0, 4'hF, 1'b0, r);
    check(tag, r, exp);
  endtask

  task automatic push_frame();
    expq.push_back(32'h0000_0000);
    for (int i = 0; i < 8; i++) expq.push_back({3'b111, model[i][28:0]});
    expq.push_back(32'hFFFF_FFFF);
  endtask

  task automatic run_frames(input bit toggle);
    int k = 0;
    m_axis_tready = 1'b1;
    while (o_busy && k < 2000) begin
      @(posedge i_clk) #1;
      if (toggle) m_axis_tready = ~m_axis_tready;
      k++;
    end
    check("frame_timeout", {31'b0, o_busy}, 32'd0);
    m_axis_tready = 1'b1;
    @(negedge i_clk);
  endtask

  initial begin
    int d0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;

    // Reset state and idle behaviour
    check("rst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    check("rst_data", m_axis_data, 32'd0);
    check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
    check("rst_done", {31'b0, o_frame_done}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clk) #1;
      check("idle_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    end
    rd_check("status_idle", 32'h44, 32'h0000_0000);

    // Basic frame
    wr(32'h00, 32'h0011_2233, 4'hF);
    wr(32'h1C, 32'hE0AA_BBCC, 4'hF);
    rd_check("led7_rb", 32'h1C, 32'hE0AA_BBCC);
    push_frame();
    d0 = done_cnt;
    wr(32'h40, 32'h1, 4'hF);
    run_frames(1'b0);
    check("done_once", 32'(done_cnt - d0), 32'd1);
    check("q_empty1", 32'(expq.size()), 32'd0);
    rd_check("status_f1", 32'h44, 32'h0000_0100);

    // Backpressure toggling
    push_frame();
    d0 = done_cnt;
    wr(32'h40, 32'h1, 4'hF);
    run_frames(1'b1);
    check("done_toggle", 32'(done_cnt - d0), 32'd1);
    check("q_empty2", 32'(expq.size()), 32'd0);

    // Multiple commits during a frame collapse to one follow-on frame
    m_axis_tready = 1'b0;
    push_frame();
    d0 = done_cnt;
    wr(32'h40, 32'h1, 4'hF);
    wr(32'h40, 32'h1, 4'hF);
    wr(32'h40, 32'h1, 4'hF);
    wr(32'h40, 32'h1, 4'hF);
    wr(32'h00, 32'h0000_0055, 4'hF);
    rd_check("status_pend", 32'h44, 32'h0000_0203);
    push_frame();
    run_frames(1'b0);
    check("done_chain", 32'(done_cnt - d0), 32'd2);
    check("q_empty3", 32'(expq.size()), 32'd0);
    rd_check("status_f4", 32'h44, 32'h0000_0400);

    // Byte-lane write and decode corners
    wr(32'h0C, 32'h1122_3344, 4'hF);
    wr(32'h0C, 32'h0000_AB00, 4'b0010);
    rd_check("byte_write", 32'h0C, 32'h1122_AB44);
    rd_check("ctrl_read", 32'h40, 32'h0000_0000);
    wr(32'h50, 32'hDEAD_BEEF, 4'hF);
    rd_check("unmapped_read", 32'h50, 32'h0000_0000);

    // Reset mid-frame while an LED word is presented
    m_axis_tready = 1'b0;
    push_frame();
    wr(32'h40, 32'h1, 4'hF);
    m_axis_tready = 1'b1;
    @(posedge i_clk) #1;
    m_axis_tready = 1'b0;
    check("mid_tvalid", {31'b0, m_axis_tvalid}, 32'd1);
    i_rst = 1'b1;
    @(posedge i_clk) #1;
    check("abort_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    check("abort_busy", {31'b0, o_busy}, 32'd0);
    i_rst = 1'b0;
    expq.delete();
    for (int i = 0; i < 8; i++) model[i] = '0;
    m_axis_tready = 1'b1;
    push_frame();
    d0 = done_cnt;
    wr(32'h40, 32'h1, 4'hF);
    run_frames(1'b0);
    check("done_post_rst", 32'(done_cnt - d0), 32'd1);
    check("q_empty4", 32'(expq.size()), 32'd0);
    rd_check("status_post_rst", 32'h44, 32'h0000_0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
